// File: rtl/dram_responder.sv
// Single-outstanding AXI-like read/write responder backed by a DEPTH x 64-bit array.
// Reads return after LAT cycles; out-of-window or misaligned addresses get SLVERR (2'b10).
`timescale 1ns/1ps
module dram_responder #(
  parameter int unsigned LAT   = 2,
  parameter logic [16:0] BASE  = 17'h10000,
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        AR_VALID,
  input  logic [16:0] AR_ADDR,
  output logic        AR_READY,
  output logic        R_VALID,
  output logic [63:0] R_DATA,
  output logic [1:0]  R_RESP,
  input  logic        R_READY,
  input  logic        AW_VALID,
  input  logic [16:0] AW_ADDR,
  output logic        AW_READY,
  input  logic        W_VALID,
  input  logic [63:0] W_DATA,
  output logic        W_READY,
  output logic        B_VALID,
  output logic [1:0]  B_RESP,
  input  logic        B_READY
);

  localparam int          IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [17:0] SPAN = 18'(8 * DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_R_WAIT,
    S_R_RESP,
    S_W_DATA,
    S_B_RESP
  } state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [16:0]   addr_q;
  logic          r_valid_q;
  logic [63:0]   r_data_q;
  logic [1:0]    r_resp_q;
  logic          b_valid_q;
  logic [1:0]    b_resp_q;
  logic [63:0]   mem_q [DEPTH];

  logic [16:0]   offset;
  logic          addr_legal;
  logic [IDXW-1:0] idx;
  logic          ar_hs;
  logic          aw_hs;
  logic          w_hs;

  // The 18-bit compare keeps the upper-bound check free of 17-bit wrap.
  assign offset     = addr_q - BASE;
  assign addr_legal = (addr_q[2:0] == 3'b000) && (addr_q >= BASE) && ({1'b0, offset} < SPAN);
  assign idx        = IDXW'(offset >> 3);

  // Ready is gated by rst_n so nothing is advertised while reset is held.
  assign AR_READY = rst_n && (state_q == S_IDLE);
  assign AW_READY = rst_n && (state_q == S_IDLE) && !AR_VALID;
  assign W_READY  = (state_q == S_W_DATA);

  assign ar_hs = AR_VALID && AR_READY;
  assign aw_hs = AW_VALID && AW_READY;
  assign w_hs  = W_VALID && W_READY;

  assign R_VALID = r_valid_q;
  assign R_DATA  = r_data_q;
  assign R_RESP  = r_resp_q;
  assign B_VALID = b_valid_q;
  assign B_RESP  = b_resp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 17'd0;
      r_valid_q <= 1'b0;
      r_data_q  <= 64'd0;
      r_resp_q  <= 2'b00;
      b_valid_q <= 1'b0;
      b_resp_q  <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ar_hs) begin
            addr_q  <= AR_ADDR;
            cnt_q   <= 4'(LAT - 1);
            state_q <= S_R_WAIT;
          end else if (aw_hs) begin
            addr_q  <= AW_ADDR;
            state_q <= S_W_DATA;
          end
        end
        S_R_WAIT: begin
          if (cnt_q == 4'd0) begin
            r_valid_q <= 1'b1;
            r_data_q  <= addr_legal ? mem_q[idx] : 64'd0;
            r_resp_q  <= addr_legal ? 2'b00 : 2'b10;
            state_q   <= S_R_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_R_RESP: begin
          if (R_READY) begin
            r_valid_q <= 1'b0;
            r_data_q  <= 64'd0;
            r_resp_q  <= 2'b00;
            state_q   <= S_IDLE;
          end
        end
        S_W_DATA: begin
          if (W_VALID) begin
            b_valid_q <= 1'b1;
            b_resp_q  <= addr_legal ? 2'b00 : 2'b10;
            state_q   <= S_B_RESP;
          end
        end
        S_B_RESP: begin
          if (B_READY) begin
            b_valid_q <= 1'b0;
            b_resp_q  <= 2'b00;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Storage clears on reset so an aborted session leaves no stale data behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 64'd0;
      end
    end else if (w_hs && addr_legal) begin
      mem_q[idx] <= W_DATA;
    end
  end

endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder: a driver queues expected responses and a
// negedge monitor pops and compares them whenever an R or B handshake occurs.
`timescale 1ns/1ps
module tb_dram_responder;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        AR_VALID = 1'b0;
  logic [16:0] AR_ADDR = '0;
  logic        AR_READY;
  logic        R_VALID;
  logic [63:0] R_DATA;
  logic [1:0]  R_RESP;
  logic        R_READY = 1'b0;
  logic        AW_VALID = 1'b0;
  logic [16:0] AW_ADDR = '0;
  logic        AW_READY;
  logic        W_VALID = 1'b0;
  logic [63:0] W_DATA = '0;
  logic        W_READY;
  logic        B_VALID;
  logic [1:0]  B_RESP;
  logic        B_READY = 1'b0;

  typedef struct {
    bit          isRead;
    logic [63:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t expQ[$];
  int   passCount = 0;
  int   totalCount = 0;

  dram_responder #(.LAT(LAT), .BASE(17'h10000), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input bit isRead, input logic [63:0] data, input logic [1:0] resp);
    exp_t e;
    e.isRead = isRead;
    e.data   = data;
    e.resp   = resp;
    expQ.push_back(e);
  endtask

  task automatic waitRValid(output int n);
    n = 0;
    while (!R_VALID && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic applyRead(input logic [16:0] addr, input logic [63:0] expData,
                           input logic [1:0] expResp, input int hold);
    int n;
    pushExp(1'b1, expData, expResp);
    AR_VALID = 1'b1;
    AR_ADDR  = addr;
    n = 0;
    while (!AR_READY && n < 50) begin
      step();
      n++;
    end
    checkOutput("ar_ready", AR_READY, 64'd1);
    step();
    AR_VALID = 1'b0;
    waitRValid(n);
    checkOutput("r_latency", n, LAT);
    for (int i = 0; i < hold; i++) begin
      checkOutput("r_hold_valid", R_VALID, 64'd1);
      checkOutput("r_hold_data", R_DATA, expData);
      checkOutput("r_hold_resp", R_RESP, expResp);
      step();
    end
    R_READY = 1'b1;
    step();
    R_READY = 1'b0;
    checkOutput("r_valid_drop", R_VALID, 64'd0);
    checkOutput("r_data_idle", R_DATA, 64'd0);
  endtask

  task automatic applyWrite(input logic [16:0] addr, input logic [63:0] data,
                            input logic [1:0] expResp, input bit wHigh);
    int n;
    pushExp(1'b0, 64'd0, expResp);
    AW_VALID = 1'b1;
    AW_ADDR  = addr;
    W_DATA   = data;
    W_VALID  = wHigh;
    B_READY  = wHigh;
    n = 0;
    while (!AW_READY && n < 50) begin
      step();
      n++;
    end
    checkOutput("aw_ready", AW_READY, 64'd1);
    step();
    AW_VALID = 1'b0;
    checkOutput("w_ready", W_READY, 64'd1);
    W_VALID = 1'b1;
    step();
    W_VALID = 1'b0;
    checkOutput("w_ready_drop", W_READY, 64'd0);
    checkOutput("b_valid", B_VALID, 64'd1);
    B_READY = 1'b1;
    step();
    B_READY = 1'b0;
    checkOutput("b_valid_drop", B_VALID, 64'd0);
    checkOutput("b_resp_idle", B_RESP, 64'd0);
  endtask

  task automatic applyStimulus();
    int n;
    // Reset values while rst_n is held low, then readiness after release.
    #12;
    checkOutput("rst_ar_ready", AR_READY, 64'd0);
    checkOutput("rst_aw_ready", AW_READY, 64'd0);
    checkOutput("rst_r_valid", R_VALID, 64'd0);
    checkOutput("rst_w_ready", W_READY, 64'd0);
    checkOutput("rst_b_valid", B_VALID, 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_ar_ready", AR_READY, 64'd1);
    checkOutput("post_rst_aw_ready", AW_READY, 64'd1);
    step();

    applyWrite(17'h10008, 64'hDEAD_BEEF_0123_4567, 2'b00, 1'b0);
    applyRead(17'h10008, 64'hDEAD_BEEF_0123_4567, 2'b00, 0);

    // Simultaneous AR and AW: read first, write only after the R handshake.
    pushExp(1'b1, 64'hDEAD_BEEF_0123_4567, 2'b00);
    pushExp(1'b0, 64'd0, 2'b00);
    AR_VALID = 1'b1;
    AR_ADDR  = 17'h10008;
    AW_VALID = 1'b1;
    AW_ADDR  = 17'h10000;
    W_DATA   = 64'h1111_2222_3333_4444;
    #1;
    checkOutput("coll_ar_ready", AR_READY, 64'd1);
    checkOutput("coll_aw_ready", AW_READY, 64'd0);
    step();
    AR_VALID = 1'b0;
    checkOutput("coll_aw_busy", AW_READY, 64'd0);
    waitRValid(n);
    checkOutput("coll_r_latency", n, LAT);
    R_READY = 1'b1;
    step();
    R_READY = 1'b0;
    checkOutput("coll_aw_after_r", AW_READY, 64'd1);
    step();
    AW_VALID = 1'b0;
    W_VALID  = 1'b1;
    step();
    W_VALID = 1'b0;
    checkOutput("coll_b_valid", B_VALID, 64'd1);
    B_READY = 1'b1;
    step();
    B_READY = 1'b0;
    applyRead(17'h10000, 64'h1111_2222_3333_4444, 2'b00, 0);

    // Illegal addresses and the last legal entry.
    applyRead(17'h10003, 64'd0, 2'b10, 0);
    applyRead(17'h0FFF8, 64'd0, 2'b10, 0);
    applyWrite(17'h107F8, 64'hA5A5_5A5A_F00D_CAFE, 2'b00, 1'b1);
    applyWrite(17'h10800, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0);
    applyRead(17'h107F8, 64'hA5A5_5A5A_F00D_CAFE, 2'b00, 0);
    applyRead(17'h10000, 64'h1111_2222_3333_4444, 2'b00, 0);

    applyRead(17'h10008, 64'hDEAD_BEEF_0123_4567, 2'b00, 5);

    // Reset during R_WAIT aborts the read and clears storage.
    applyWrite(17'h10010, 64'h0BAD_F00D_1234_5678, 2'b00, 1'b0);
    AR_VALID = 1'b1;
    AR_ADDR  = 17'h10010;
    step();
    AR_VALID = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ar_ready", AR_READY, 64'd0);
    checkOutput("mid_rst_aw_ready", AW_READY, 64'd0);
    checkOutput("mid_rst_r_valid", R_VALID, 64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      step();
      checkOutput("abort_r_valid", R_VALID, 64'd0);
    end
    checkOutput("abort_ar_ready", AR_READY, 64'd1);
    applyRead(17'h10010, 64'd0, 2'b00, 0);
    applyRead(17'h10008, 64'd0, 2'b00, 0);

    // Reset during W_DATA drops the pending write.
    AW_VALID = 1'b1;
    AW_ADDR  = 17'h10018;
    W_DATA   = 64'h7777_8888_9999_AAAA;
    step();
    AW_VALID = 1'b0;
    checkOutput("wabort_w_ready", W_READY, 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("wabort_rst_w_ready", W_READY, 64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("wabort_b_valid", B_VALID, 64'd0);
    end
    applyRead(17'h10018, 64'd0, 2'b00, 0);

    step();
    step();
    checkOutput("queue_empty", expQ.size(), 64'd0);
  endtask

  // Monitor: every R/B handshake must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (R_VALID && R_READY) begin
        if (expQ.size() == 0) begin
          totalCount++;
          $display("[TB] FAIL r_unexpected: got R response, expected none");
        end else begin
          e = expQ.pop_front();
          checkOutput("r_kind", {63'd0, e.isRead}, 64'd1);
          checkOutput("r_data", R_DATA, e.data);
          checkOutput("r_resp", R_RESP, e.resp);
        end
      end
      if (B_VALID && B_READY) begin
        if (expQ.size() == 0) begin
          totalCount++;
          $display("[TB] FAIL b_unexpected: got B response, expected none");
        end else begin
          e = expQ.pop_front();
          checkOutput("b_kind", {63'd0, e.isRead}, 64'd0);
          checkOutput("b_resp", B_RESP, e.resp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
